// File: rtl/axis_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_wr_arbiter_if
// Description : Bundle of NUM_SRC AXI-Stream source channels, the shared FIFO
//               write channel and the arbiter status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [NUM_SRC-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tlast;
  logic                          m_tready;
  logic                          grant_valid;
  logic [SRC_W-1:0]              grant_id;
  logic                          timeout_err;

  // Arbiter view: consumes the sources and FIFO ready, drives everything else.
  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast,
    output grant_valid, grant_id, timeout_err
  );

  // Environment view: the sources and the FIFO write port.
  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast,
    input  grant_valid, grant_id, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/axis_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_wr_arbiter
// Description : Packet-level round-robin arbiter sharing the axis_fifo write
//               port among NUM_SRC sources; grant held until tlast.
//               Optional stall watchdog enabled by macro ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_wr_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SRC        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic           wclk,
  input  wire logic           wrst_n,
  axis_wr_arbiter_if.master   bus
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int c_CW  = SRC_W + 1;
  localparam logic [SRC_W:0]   c_NSRC      = c_CW'(NUM_SRC);
  localparam logic [SRC_W-1:0] c_LAST_INIT = SRC_W'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SRC_W-1:0]      r_grant_id;
  logic [SRC_W-1:0]      w_grant_id_nxt;
  logic [SRC_W-1:0]      r_last_grant;
  logic [SRC_W-1:0]      w_last_grant_nxt;
  logic [SRC_W-1:0]      w_winner;
  logic [SRC_W:0]        w_cand;
  logic                  w_any_req;
  logic                  w_busy;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_beat;
  logic                  w_timeout;

  assign w_busy      = (r_state == ST_BUSY);
  assign w_sel_valid = bus.s_tvalid[r_grant_id];
  assign w_sel_last  = bus.s_tlast[r_grant_id];
  assign w_sel_data  = bus.s_tdata[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign w_beat      = w_busy && w_sel_valid && bus.m_tready;

  // Search last_grant+1, last_grant+2, ... wrapping at NUM_SRC (any count).
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = r_last_grant;
    w_cand    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = {1'b0, r_last_grant} + c_CW'(k);
      if (w_cand >= c_NSRC) begin
        w_cand = w_cand - c_NSRC;
      end
      if (!w_any_req && bus.s_tvalid[w_cand[SRC_W-1:0]]) begin
        w_any_req = 1'b1;
        w_winner  = w_cand[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = ST_BUSY;
          w_grant_id_nxt = w_winner;
        end
      end
      ST_BUSY: begin
        if ((w_beat && w_sel_last) || w_timeout) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant_id;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= c_LAST_INIT;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Outputs decode from the registered state so an async reset drops them at once.
  assign bus.m_tvalid    = w_busy && w_sel_valid;
  assign bus.m_tlast     = w_busy && w_sel_last;
  assign bus.m_tdata     = w_busy ? w_sel_data : '0;
  assign bus.grant_valid = w_busy;
  assign bus.grant_id    = r_grant_id;

  always_comb begin
    bus.s_tready = '0;
    if (w_busy) begin
      bus.s_tready[r_grant_id] = bus.m_tready;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int c_STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_STALL_W-1:0] c_STALL_LIM = c_STALL_W'(TIMEOUT_CYCLES - 1);

  logic [c_STALL_W-1:0] r_stall;
  logic                 r_timeout_err;

  // Only cycles with the owner's tvalid low count; FIFO back-pressure is not a stall.
  assign w_timeout = w_busy && !w_sel_valid && (r_stall == c_STALL_LIM);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_stall       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (!w_busy || w_beat || w_timeout) begin
        r_stall <= '0;
      end else if (!w_sel_valid) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_wr_arbiter
// Description : Directed and random stimulus for axis_wr_arbiter checked
//               against a packet-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_wr_arbiter;
  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int TO    = 8;
  localparam int DEPTH = 64;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  axis_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(N)) bus ();

  axis_wr_arbiter #(
    .DATA_WIDTH     (DW),
    .NUM_SRC        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  // Source beat stores and FIFO-side ready.
  logic [DW-1:0] bd [N][DEPTH];
  logic          bl [N][DEPTH];
  int            hd [N];
  int            tl [N];
  bit            en [N];
  bit            rdy;

  // Reference model: who owns the port, who was served last, stall count.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_stall;
  bit m_err;

  int n_assert = 0;
  int n_fail   = 0;
  int glog[$];
  int dlog[$];
  bit prev_gv;
  int err_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has(input int s);
    return en[s] && (hd[s] < tl[s]);
  endfunction

  function automatic bit pending();
    bit p = m_busy;
    for (int i = 0; i < N; i++) p |= has(i);
    return p;
  endfunction

  task automatic push_pkt(input int s, input int len, input logic [DW-1:0] base, input bit rnd);
    if (hd[s] == tl[s]) begin
      hd[s] = 0;
      tl[s] = 0;
    end
    for (int j = 0; j < len; j++) begin
      bd[s][tl[s]] = rnd ? DW'($urandom) : base;
      bl[s][tl[s]] = (j == len - 1);
      tl[s]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.s_tvalid[i]        = has(i);
      bus.s_tlast[i]         = 1'b0;
      bus.s_tdata[i*DW +: DW] = '0;
      if (has(i)) begin
        bus.s_tlast[i]          = bl[i][hd[i]];
        bus.s_tdata[i*DW +: DW] = bd[i][hd[i]];
      end
    end
    bus.m_tready = rdy;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_stall = 0; m_err = 0;
    prev_gv = 0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0; tl[i] = 0; en[i] = 1;
    end
  endtask

  // One clock: drive at negedge, check 1ns later, advance model, wait posedge.
  task automatic tick();
    logic [31:0] exp_rdy;
    bit ev;
    bit nerr;
    @(negedge wclk);
    drive();
    #1;
    chk("grant_valid", 32'(bus.grant_valid), 32'(m_busy));
    chk("grant_id", 32'(bus.grant_id), 32'(m_owner));
    exp_rdy = (m_busy && rdy) ? (32'd1 << m_owner) : 32'd0;
    chk("s_tready", 32'(bus.s_tready), exp_rdy);
    ev = m_busy && has(m_owner);
    chk("m_tvalid", 32'(bus.m_tvalid), 32'(ev));
    if (ev) begin
      chk("m_tdata", 32'(bus.m_tdata), 32'(bd[m_owner][hd[m_owner]]));
      chk("m_tlast", 32'(bus.m_tlast), 32'(bl[m_owner][hd[m_owner]]));
    end
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    if (bus.grant_valid && !prev_gv) glog.push_back(int'(bus.grant_id));
    prev_gv = bus.grant_valid;
    if (bus.timeout_err) err_seen++;
    if (bus.m_tvalid && bus.m_tready) dlog.push_back(int'({bus.m_tlast, bus.m_tdata}));

    nerr = 0;
    if (m_busy) begin
      if (ev && rdy) begin
        m_stall = 0;
        if (bl[m_owner][hd[m_owner]]) begin
          m_busy = 0;
          m_last = m_owner;
        end
        hd[m_owner]++;
      end else if (!ev) begin
`ifdef ARB_WATCHDOG_EN
        m_stall++;
        if (m_stall == TO) begin
          m_busy = 0;
          m_last = m_owner;
          nerr   = 1;
        end
`endif
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!m_busy && has((m_last + k) % N)) begin
          m_busy  = 1;
          m_owner = (m_last + k) % N;
          m_stall = 0;
        end
      end
    end
    m_err = nerr;
    @(posedge wclk);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (pending() && c < budget) begin
      tick();
      c++;
    end
    chk("drain_in_budget", 32'(c < budget), 32'd1);
  endtask

  initial begin
    int exp_d;
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b0;
    rdy = 1;
    model_reset();
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Idle after reset.
    repeat (20) tick();

    // Four simultaneous 3-beat packets: served 0,1,2,3 with one bubble each.
    glog.delete(); dlog.delete();
    for (int i = 0; i < N; i++) push_pkt(i, 3, DW'(8'hA0 + i), 0);
    drain(40);
    chk("rr_order_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i));
    chk("rr_beats", 32'(dlog.size()), 32'd12);
    for (int b = 0; b < 12 && b < dlog.size(); b++) begin
      exp_d = ((b % 3 == 2) ? 256 : 0) + 8'hA0 + b / 3;
      chk("rr_data", 32'(dlog[b]), 32'(exp_d));
    end

    // Back-pressure on source 1 mid-packet while source 2 waits.
    push_pkt(1, 4, 8'h10, 0);
    tick(); tick();
    push_pkt(2, 3, 8'h20, 0);
    rdy = 0;
    repeat (10) begin
      tick();
      #1;
      chk("bp_hold_gid", 32'(bus.grant_id), 32'd1);
      chk("bp_src2_blocked", 32'(bus.s_tready[2]), 32'd0);
    end
    rdy = 1;
    glog.delete();
    drain(40);
    chk("bp_next_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 32'd2);

    // After source 2, sources 0 and 3 request together: 3 then 0.
    glog.delete();
    push_pkt(0, 2, 8'h30, 0);
    push_pkt(3, 2, 8'h33, 0);
    drain(40);
    chk("rr_after2_first", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 32'd3);
    chk("rr_after2_second", (glog.size() > 1) ? 32'(glog[1]) : 32'hFFFF, 32'd0);

    // Asynchronous reset on beat 2 of a 4-beat packet.
    push_pkt(2, 4, 8'h44, 0);
    tick(); tick();
    @(negedge wclk);
    drive();
    #1;
    chk("rst_beat2_present", 32'(bus.m_tvalid), 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
    model_reset();
    drive();
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    glog.delete();
    push_pkt(3, 1, 8'h53, 0);
    push_pkt(0, 1, 8'h50, 0);
    drain(20);
    chk("rst_prio_first", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 32'd0);
    chk("rst_prio_second", (glog.size() > 1) ? 32'(glog[1]) : 32'hFFFF, 32'd3);

    // Owner goes silent after one beat while source 2 waits.
    push_pkt(1, 2, 8'h61, 0);
    for (int c = 0; c < 10 && hd[1] < 1; c++) tick();
    en[1] = 0;
    push_pkt(2, 1, 8'h62, 0);
    glog.delete();
    err_seen = 0;
    repeat (TO + 6) tick();
    #1;
`ifdef ARB_WATCHDOG_EN
    chk("wd_err_pulses", 32'(err_seen), 32'd1);
    chk("wd_next_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 32'd2);
`else
    chk("hold_grant_valid", 32'(bus.grant_valid), 32'd1);
    chk("hold_grant_id", 32'(bus.grant_id), 32'd1);
    chk("hold_no_regrant", 32'(glog.size()), 32'd0);
`endif
    en[1] = 1;
    drain(60);

    // Random traffic and random FIFO back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++) begin
        if (hd[s] == tl[s] && $urandom_range(3) == 0)
          push_pkt(s, int'($urandom_range(1, 5)), '0, 1);
      end
      rdy = ($urandom_range(3) != 0);
      tick();
    end
    rdy = 1;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
